// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RACK_WAIT = 4'd8
  } i2c_state_t;

  localparam logic ACK         = 1'b0;
  localparam logic NACK        = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

  // Register pointer advance; wraps 0xFF -> 0x00 by construction.
  function automatic logic [7:0] ptr_inc(input logic [7:0] p);
    return p + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronises the SCL/SDA pads and derives SCL edges plus START/STOP events.
module i2c_bus_cond (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_hist_r;
  logic       sda_hist_r;

  // Two-flop synchronisers plus one history flop; idle bus reads high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_i};
      sda_sync_r <= {sda_sync_r[0], sda_i};
      scl_hist_r <= scl_sync_r[1];
      sda_hist_r <= sda_sync_r[1];
    end
  end

  assign scl_rise  = scl_sync_r[1] & ~scl_hist_r;
  assign scl_fall  = ~scl_sync_r[1] & scl_hist_r;
  assign start_det = scl_sync_r[1] & scl_hist_r & sda_hist_r & ~sda_sync_r[1];
  assign stop_det  = scl_sync_r[1] & scl_hist_r & ~sda_hist_r & sda_sync_r[1];
  assign sda_s     = sda_sync_r[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target serving an 8-bit register file through an auto-incrementing pointer.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h69,
  parameter int         NREGS    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int         IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [8:0] NREGS_L = 9'(NREGS);

  logic       scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_sync_s;
  i2c_state_t state_r, state_nx_s;
  logic [2:0] bit_cnt_r, bit_cnt_nx_s;
  logic [7:0] shift_r, shift_nx_s;
  logic [7:0] ptr_r, ptr_nx_s;
  logic       rw_r, rw_nx_s;
  logic       byte_done_r, byte_done_nx_s;
  logic       sda_oe_r, sda_oe_nx_s;
  logic       busy_r, busy_nx_s;
  logic       wr_en_s;
  logic       ptr_ok_s, host_ok_s;
  logic [7:0] rx_byte_s, rd_byte_s;
  logic [7:0] regs_r [NREGS];
  logic [7:0] host_rdata_r, wr_addr_r, wr_data_r;
  logic       wr_pulse_r;

  i2c_bus_cond u_bus_cond (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_det_s),
    .stop_det  (stop_det_s),
    .sda_s     (sda_sync_s)
  );

  assign rx_byte_s = {shift_r[6:0], sda_sync_s};
  assign ptr_ok_s  = ({1'b0, ptr_r} < NREGS_L);
  assign host_ok_s = ({1'b0, host_addr} < NREGS_L);

  // Byte presented to the master; locations past the array read as zero.
  always_comb begin
    rd_byte_s = 8'h00;
    if (ptr_ok_s) begin
      rd_byte_s = regs_r[ptr_r[IDX_W-1:0]];
    end else begin
      rd_byte_s = 8'h00;
    end
  end

  // Next-state logic: STOP beats START beats the per-state bit handling.
  always_comb begin
    state_nx_s     = state_r;
    bit_cnt_nx_s   = bit_cnt_r;
    shift_nx_s     = shift_r;
    ptr_nx_s       = ptr_r;
    rw_nx_s        = rw_r;
    byte_done_nx_s = byte_done_r;
    sda_oe_nx_s    = sda_oe_r;
    busy_nx_s      = busy_r;
    wr_en_s        = 1'b0;
    if (stop_det_s) begin
      state_nx_s     = IDLE;
      sda_oe_nx_s    = 1'b0;
      busy_nx_s      = 1'b0;
      byte_done_nx_s = 1'b0;
    end else if (start_det_s) begin
      state_nx_s     = ADDR;
      bit_cnt_nx_s   = 3'd0;
      byte_done_nx_s = 1'b0;
      sda_oe_nx_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sda_oe_nx_s = 1'b0;
        end
        ADDR, PTR, WDATA: begin
          if (scl_rise_s && !byte_done_r) begin
            shift_nx_s   = rx_byte_s;
            bit_cnt_nx_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              byte_done_nx_s = 1'b1;
              if (state_r == WDATA) begin
                wr_en_s  = 1'b1;
                ptr_nx_s = ptr_inc(ptr_r);
              end else begin
                wr_en_s = 1'b0;
              end
            end else begin
              byte_done_nx_s = 1'b0;
            end
          end else if (scl_fall_s && byte_done_r) begin
            byte_done_nx_s = 1'b0;
            case (state_r)
              ADDR: begin
                if (shift_r[7:1] == DEV_ADDR) begin
                  rw_nx_s     = shift_r[0];
                  sda_oe_nx_s = 1'b1;
                  busy_nx_s   = 1'b1;
                  state_nx_s  = ADDR_ACK;
                end else begin
                  sda_oe_nx_s = 1'b0;
                  busy_nx_s   = 1'b0;
                  state_nx_s  = IDLE;
                end
              end
              PTR: begin
                ptr_nx_s    = shift_r;
                sda_oe_nx_s = 1'b1;
                state_nx_s  = PTR_ACK;
              end
              WDATA: begin
                sda_oe_nx_s = 1'b1;
                state_nx_s  = WDATA_ACK;
              end
              default: begin
                sda_oe_nx_s = 1'b0;
                state_nx_s  = IDLE;
              end
            endcase
          end else begin
            byte_done_nx_s = byte_done_r;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_nx_s = 3'd0;
            if (rw_r == I2C_RW_READ) begin
              shift_nx_s  = rd_byte_s;
              sda_oe_nx_s = ~rd_byte_s[7];
              state_nx_s  = RDATA;
            end else begin
              sda_oe_nx_s = 1'b0;
              state_nx_s  = PTR;
            end
          end else begin
            sda_oe_nx_s = sda_oe_r;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_nx_s = 3'd0;
            sda_oe_nx_s  = 1'b0;
            state_nx_s   = WDATA;
          end else begin
            sda_oe_nx_s = sda_oe_r;
          end
        end
        RDATA: begin
          // Bit 7 went out on entry; each fall presents the next lower bit.
          if (scl_fall_s) begin
            bit_cnt_nx_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              sda_oe_nx_s    = 1'b0;
              byte_done_nx_s = 1'b0;
              state_nx_s     = RACK_WAIT;
            end else begin
              sda_oe_nx_s = ~shift_r[6];
              shift_nx_s  = {shift_r[6:0], 1'b0};
            end
          end else begin
            sda_oe_nx_s = sda_oe_r;
          end
        end
        RACK_WAIT: begin
          if (scl_rise_s && !byte_done_r) begin
            if (sda_sync_s == ACK) begin
              ptr_nx_s       = ptr_inc(ptr_r);
              byte_done_nx_s = 1'b1;
            end else begin
              sda_oe_nx_s = 1'b0;
              busy_nx_s   = 1'b0;
              state_nx_s  = IDLE;
            end
          end else if (scl_fall_s && byte_done_r) begin
            byte_done_nx_s = 1'b0;
            bit_cnt_nx_s   = 3'd0;
            shift_nx_s     = rd_byte_s;
            sda_oe_nx_s    = ~rd_byte_s[7];
            state_nx_s     = RDATA;
          end else begin
            sda_oe_nx_s = 1'b0;
          end
        end
        default: begin
          sda_oe_nx_s = 1'b0;
          busy_nx_s   = 1'b0;
          state_nx_s  = IDLE;
        end
      endcase
    end
  end

  // FSM and protocol registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      ptr_r       <= 8'h00;
      rw_r        <= 1'b0;
      byte_done_r <= 1'b0;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      bit_cnt_r   <= bit_cnt_nx_s;
      shift_r     <= shift_nx_s;
      ptr_r       <= ptr_nx_s;
      rw_r        <= rw_nx_s;
      byte_done_r <= byte_done_nx_s;
      sda_oe_r    <= sda_oe_nx_s;
      busy_r      <= busy_nx_s;
    end
  end

  // Register file, write strobe and host read port (read sees pre-write data).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
      host_rdata_r <= 8'h00;
      wr_pulse_r   <= 1'b0;
      wr_addr_r    <= 8'h00;
      wr_data_r    <= 8'h00;
    end else begin
      host_rdata_r <= host_ok_s ? regs_r[host_addr[IDX_W-1:0]] : 8'h00;
      wr_pulse_r   <= wr_en_s & ptr_ok_s;
      if (wr_en_s && ptr_ok_s) begin
        regs_r[ptr_r[IDX_W-1:0]] <= rx_byte_s;
        wr_addr_r                <= ptr_r;
        wr_data_r                <= rx_byte_s;
      end
    end
  end

  assign sda_oe     = sda_oe_r;
  assign busy       = busy_r;
  assign host_rdata = host_rdata_r;
  assign wr_pulse   = wr_pulse_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bit-banged I2C master with a wired-AND SDA and a register-file reference model.
module tb_i2c_target_regfile;

  localparam int         Q   = 5;
  localparam logic [6:0] DEV = 7'h69;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] host_addr, host_rdata, wr_addr, wr_data;
  logic       wr_pulse, busy;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [7:0] last_wr_addr, last_wr_data, snap_rdata;

  logic [7:0] model_regs [256];
  logic [7:0] model_ptr;
  logic [7:0] txbuf  [8];
  logic [7:0] rxbuf  [8];
  logic [7:0] expbuf [8];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      wr_count++;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
      snap_rdata   = host_rdata;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    model_ptr = 8'h00;
  endfunction

  function automatic void model_write(input logic [7:0] d);
    if (model_ptr < 8'd64) model_regs[model_ptr] = d;
    model_ptr = model_ptr + 8'd1;
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] p);
    return (p < 8'd64) ? model_regs[p] : 8'h00;
  endfunction

  // Expected read data; the last byte is NACKed so the pointer stops on it.
  function automatic void expect_read(input logic [7:0] p, input int n);
    logic [7:0] q;
    q = p;
    for (int i = 0; i < n; i++) begin
      expbuf[i] = model_byte(q);
      if (i < n - 1) q = q + 8'd1;
    end
    model_ptr = q;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    s = sda_bus;  tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    acked = (s == 1'b0);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(ack_bit, s);
  endtask

  task automatic write_txn(input logic [7:0] p, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    send_byte({DEV, 1'b0}, a); if (a) acks++;
    send_byte(p, a);           if (a) acks++;
    model_ptr = p;
    for (int i = 0; i < n; i++) begin
      send_byte(txbuf[i], a); if (a) acks++;
      model_write(txbuf[i]);
    end
    bus_stop();
  endtask

  task automatic read_txn(input logic [7:0] p, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    send_byte({DEV, 1'b0}, a); if (a) acks++;
    send_byte(p, a);           if (a) acks++;
    bus_start();
    send_byte({DEV, 1'b1}, a); if (a) acks++;
    for (int i = 0; i < n; i++) recv_byte((i == n - 1) ? 1'b1 : 1'b0, rxbuf[i]);
    bus_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_addr = 8'h00;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(2);
    checks++; if (sda_oe !== 1'b0)      begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (wr_pulse !== 1'b0)    begin errors++; $display("FAIL reset_wr_pulse got %b exp 0", wr_pulse); end
    checks++; if (wr_addr !== 8'h00)    begin errors++; $display("FAIL reset_wr_addr got %h exp 00", wr_addr); end
    checks++; if (wr_data !== 8'h00)    begin errors++; $display("FAIL reset_wr_data got %h exp 00", wr_data); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_rdata got %h exp 00", host_rdata); end
  endtask

  task automatic test_single_write();
    int acks, wc;
    wc = wr_count;
    txbuf[0] = 8'h14;
    write_txn(8'h25, 1, acks);
    host_addr = 8'h25; tick(2);
    checks++; if (acks != 3)              begin errors++; $display("FAIL write_acks got %0d exp 3", acks); end
    checks++; if (wr_count != wc + 1)     begin errors++; $display("FAIL write_pulses got %0d exp %0d", wr_count - wc, 1); end
    checks++; if (last_wr_addr !== 8'h25) begin errors++; $display("FAIL write_addr got %h exp 25", last_wr_addr); end
    checks++; if (last_wr_data !== 8'h14) begin errors++; $display("FAIL write_data got %h exp 14", last_wr_data); end
    checks++; if (host_rdata !== model_regs[8'h25]) begin errors++; $display("FAIL write_host got %h exp %h", host_rdata, model_regs[8'h25]); end
  endtask

  task automatic test_read_back();
    logic a0, a1, a2, busy_mid;
    logic [7:0] b0, b1;
    expect_read(8'h25, 2);
    bus_start();
    send_byte({DEV, 1'b0}, a0);
    send_byte(8'h25, a1);
    bus_start();
    send_byte({DEV, 1'b1}, a2);
    busy_mid = busy;
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    tick(2);
    checks++; if (!(a0 && a1 && a2))  begin errors++; $display("FAIL read_acks got %b%b%b exp 111", a0, a1, a2); end
    checks++; if (busy_mid !== 1'b1)  begin errors++; $display("FAIL read_busy_mid got %b exp 1", busy_mid); end
    checks++; if (b0 !== expbuf[0])   begin errors++; $display("FAIL read_byte0 got %h exp %h", b0, expbuf[0]); end
    checks++; if (b1 !== expbuf[1])   begin errors++; $display("FAIL read_byte1 got %h exp %h", b1, expbuf[1]); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL read_busy_after_nack got %b exp 0", busy); end
    bus_stop();
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int wc;
    wc = wr_count;
    bus_start();
    send_byte({7'h68, 1'b0}, a0);
    checks++; if (a0 !== 1'b0)   begin errors++; $display("FAIL mismatch_ack got %b exp 0", a0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy got %b exp 0", busy); end
    send_byte(8'h25, a1);
    send_byte(8'h77, a1);
    bus_stop();
    checks++; if (a1 !== 1'b0)     begin errors++; $display("FAIL mismatch_data_ack got %b exp 0", a1); end
    checks++; if (wr_count != wc)  begin errors++; $display("FAIL mismatch_pulses got %0d exp 0", wr_count - wc); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mismatch_sda_oe got %b exp 0", sda_oe); end
  endtask

  task automatic test_burst_wrap();
    int acks;
    txbuf[0] = 8'($urandom_range(1, 255));
    write_txn(8'h00, 1, acks);
    txbuf[0] = 8'hAA; txbuf[1] = 8'hBB;
    write_txn(8'h3F, 2, acks);
    checks++; if (acks != 4) begin errors++; $display("FAIL burst_acks got %0d exp 4", acks); end
    host_addr = 8'h3F; tick(2);
    checks++; if (host_rdata !== model_regs[8'h3F]) begin errors++; $display("FAIL burst_reg63 got %h exp %h", host_rdata, model_regs[8'h3F]); end
    host_addr = 8'h00; tick(2);
    checks++; if (host_rdata !== model_regs[8'h00]) begin errors++; $display("FAIL burst_reg0 got %h exp %h", host_rdata, model_regs[8'h00]); end
    expect_read(8'hFF, 2);
    read_txn(8'hFF, 2, acks);
    checks++; if (acks != 3)             begin errors++; $display("FAIL wrap_acks got %0d exp 3", acks); end
    checks++; if (rxbuf[0] !== expbuf[0]) begin errors++; $display("FAIL wrap_byte0 got %h exp %h", rxbuf[0], expbuf[0]); end
    checks++; if (rxbuf[1] !== expbuf[1]) begin errors++; $display("FAIL wrap_byte1 got %h exp %h", rxbuf[1], expbuf[1]); end
  endtask

  task automatic test_stop_partial();
    logic a, s;
    logic [7:0] d;
    int wc, acks;
    wc = wr_count;
    d = 8'($urandom);
    bus_start();
    send_byte({DEV, 1'b0}, a);
    send_byte(8'h10, a);
    for (int i = 7; i >= 4; i--) bus_bit(d[i], s);
    bus_stop();
    tick(2);
    host_addr = 8'h10; tick(2);
    checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL partial_sda_oe got %b exp 0", sda_oe); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL partial_busy got %b exp 0", busy); end
    checks++; if (wr_count != wc)    begin errors++; $display("FAIL partial_pulses got %0d exp 0", wr_count - wc); end
    checks++; if (host_rdata !== model_regs[8'h10]) begin errors++; $display("FAIL partial_reg got %h exp %h", host_rdata, model_regs[8'h10]); end
    txbuf[0] = ~model_regs[8'h10];
    write_txn(8'h10, 1, acks);
    tick(2);
    checks++; if (acks != 3) begin errors++; $display("FAIL partial_next_acks got %0d exp 3", acks); end
    checks++; if (host_rdata !== model_regs[8'h10]) begin errors++; $display("FAIL partial_next_reg got %h exp %h", host_rdata, model_regs[8'h10]); end
  endtask

  task automatic test_same_cycle_read();
    logic [7:0] old_val;
    int acks;
    old_val = model_regs[8'h20];
    host_addr = 8'h20;
    txbuf[0] = old_val ^ 8'h5A;
    write_txn(8'h20, 1, acks);
    tick(2);
    checks++; if (snap_rdata !== old_val) begin errors++; $display("FAIL same_cycle_old got %h exp %h", snap_rdata, old_val); end
    checks++; if (host_rdata !== model_regs[8'h20]) begin errors++; $display("FAIL same_cycle_new got %h exp %h", host_rdata, model_regs[8'h20]); end
  endtask

  task automatic test_rst_mid_read();
    logic a;
    int acks;
    txbuf[0] = {1'b0, 7'($urandom)};
    write_txn(8'h30, 1, acks);
    bus_start();
    send_byte({DEV, 1'b0}, a);
    send_byte(8'h30, a);
    bus_start();
    send_byte({DEV, 1'b1}, a);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_drive got %b exp 1", sda_oe); end
    rst = 1'b1; tick(1);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b exp 0", sda_oe); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst = 1'b0;
    model_reset();
    host_addr = 8'h30; tick(2);
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL rst_regs got %h exp 00", host_rdata); end
    txbuf[0] = 8'($urandom);
    write_txn(8'h05, 1, acks);
    checks++; if (acks != 3) begin errors++; $display("FAIL rst_recover_acks got %0d exp 3", acks); end
    expect_read(8'h05, 1);
    read_txn(8'h05, 1, acks);
    checks++; if (rxbuf[0] !== expbuf[0]) begin errors++; $display("FAIL rst_recover_byte got %h exp %h", rxbuf[0], expbuf[0]); end
  endtask

  task automatic test_random();
    int n, acks;
    logic [7:0] p, ha;
    for (int it = 0; it < 4; it++) begin
      p = 8'($urandom_range(0, 70));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) txbuf[i] = 8'($urandom);
      write_txn(p, n, acks);
      checks++; if (acks != n + 2) begin errors++; $display("FAIL rand_write_acks it%0d got %0d exp %0d", it, acks, n + 2); end
      expect_read(p, n);
      read_txn(p, n, acks);
      for (int i = 0; i < n; i++) begin
        checks++; if (rxbuf[i] !== expbuf[i]) begin errors++; $display("FAIL rand_read it%0d byte%0d got %h exp %h", it, i, rxbuf[i], expbuf[i]); end
      end
      ha = 8'($urandom_range(0, 80));
      host_addr = ha; tick(2);
      checks++; if (host_rdata !== model_byte(ha)) begin errors++; $display("FAIL rand_host addr %h got %h exp %h", ha, host_rdata, model_byte(ha)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_addr_mismatch();
    test_burst_wrap();
    test_stop_partial();
    test_same_cycle_read();
    test_rst_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
